// File: rtl/axi4lite_tohost_mailbox_if.sv
// AXI4-Lite channel bundle for the tohost mailbox window.
// Pure wiring, no latency; flow control is the standard AXI valid/ready pairs.
// The master drives the request channels and the slave drives the response channels.
interface axi4lite_tohost_mailbox_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic [3:0]  awcache;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic [3:0]  arcache;
   logic        rvalid;
   logic        rready;
   logic [1:0]  rresp;
   logic [31:0] rdata;

   modport master (
      output awvalid, awaddr, awprot, awcache, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, arcache, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
   );

   modport slave (
      input  awvalid, awaddr, awprot, awcache, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, arcache, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
   );
endinterface

// File: rtl/axi4lite_tohost_mailbox.sv
// AXI4-Lite tohost/fromhost mailbox with sticky pass/fail status and a cycle counter.
// Latency: bvalid one cycle after the later of AW/W; rvalid one cycle after AR.
// Backpressure: B and R responses are held until bready/rready; AW/W/AR stall while a response is pending.
module axi4lite_tohost_mailbox #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_6000,
   parameter logic [31:0] SUCCESS_CODE = 32'd1
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   axi4lite_tohost_mailbox_if.slave         axi,
   output logic                             host_done,
   output logic                             host_pass,
   output logic [31:0]                      host_code
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_RESP} r_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_req_t;

   w_state_e    w_state_q, w_state_d;
   r_state_e    r_state_q, r_state_d;
   wr_req_t     wr_q, wr_d, wr_eff;
   logic        awready_q, awready_d;
   logic        wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] tohost_q, tohost_d;
   logic [31:0] fromhost_q, fromhost_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [31:0] code_q, code_d;
   logic [31:0] cycles_q, cycles_d;
   logic        aw_hs, w_hs, ar_hs, commit;
   logic [31:0] merged;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

   function automatic logic in_window(input logic [31:0] addr);
      return addr[31:4] == BASE_ADDR[31:4];
   endfunction

   always_comb begin : write_path
      w_state_d  = w_state_q;
      wr_d       = wr_q;
      bresp_d    = bresp_q;
      tohost_d   = tohost_q;
      fromhost_d = fromhost_q;
      done_d     = done_q;
      pass_d     = pass_q;
      code_d     = code_q;
      commit     = 1'b0;
      merged     = 32'd0;
      aw_hs      = axi.awvalid && awready_q;
      w_hs       = axi.wvalid && wready_q;

      // wr_d carries the live beat when it handshakes now, else the held one.
      if (aw_hs) wr_d.addr = axi.awaddr;
      if (w_hs) begin
         wr_d.data = axi.wdata;
         wr_d.strb = axi.wstrb;
      end
      wr_eff = wr_d;

      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit    = 1'b1;
               w_state_d = W_RESP;
            end else if (aw_hs) begin
               w_state_d = W_ADDR;
            end else if (w_hs) begin
               w_state_d = W_DATA;
            end
         end
         W_ADDR: begin
            if (w_hs) begin
               commit    = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_DATA: begin
            if (aw_hs) begin
               commit    = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (axi.bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase

      if (commit) begin
         if (!in_window(wr_eff.addr)) begin
            bresp_d = RESP_DECERR;
         end else begin
            case (wr_eff.addr[3:2])
               2'd0: begin
                  merged   = merge_bytes(tohost_q, wr_eff.data, wr_eff.strb);
                  tohost_d = merged;
                  bresp_d  = RESP_OKAY;
                  // First nonzero value latches the verdict; later writes leave it frozen.
                  if (!done_q && merged != 32'd0) begin
                     done_d = 1'b1;
                     code_d = merged;
                     pass_d = (merged == SUCCESS_CODE);
                  end
               end
               2'd1: begin
                  fromhost_d = merge_bytes(fromhost_q, wr_eff.data, wr_eff.strb);
                  bresp_d    = RESP_OKAY;
               end
               default: bresp_d = RESP_SLVERR;
            endcase
         end
      end

      awready_d = (w_state_d == W_IDLE) || (w_state_d == W_DATA);
      wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_ADDR);
      bvalid_d  = (w_state_d == W_RESP);
   end

   always_comb begin : read_path
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      ar_hs     = axi.arvalid && arready_q;

      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_RESP;
               if (!in_window(axi.araddr)) begin
                  rresp_d = RESP_DECERR;
                  rdata_d = 32'd0;
               end else begin
                  rresp_d = RESP_OKAY;
                  // Sources are the _q values, so a colliding write is not yet visible.
                  case (axi.araddr[3:2])
                     2'd0:    rdata_d = tohost_q;
                     2'd1:    rdata_d = fromhost_q;
                     2'd2:    rdata_d = {30'd0, pass_q, done_q};
                     default: rdata_d = cycles_q;
                  endcase
               end
            end
         end
         R_RESP: begin
            if (axi.rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase

      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_RESP);
   end

   assign cycles_d = cycles_q + 32'd1;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q  <= W_IDLE;
         r_state_q  <= R_IDLE;
         wr_q       <= '0;
         awready_q  <= 1'b1;
         wready_q   <= 1'b1;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         arready_q  <= 1'b1;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= 32'd0;
         tohost_q   <= 32'd0;
         fromhost_q <= 32'd0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         code_q     <= 32'd0;
         cycles_q   <= 32'd0;
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         wr_q       <= wr_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         tohost_q   <= tohost_d;
         fromhost_q <= fromhost_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         code_q     <= code_d;
         cycles_q   <= cycles_d;
      end
   end

   assign axi.awready = awready_q;
   assign axi.wready  = wready_q;
   assign axi.bvalid  = bvalid_q;
   assign axi.bresp   = bresp_q;
   assign axi.arready = arready_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.rresp   = rresp_q;
   assign axi.rdata   = rdata_q;
   assign host_done   = done_q;
   assign host_pass   = pass_q;
   assign host_code   = code_q;

   logic unused_ok;
   assign unused_ok = ^{axi.awprot, axi.awcache, axi.arprot, axi.arcache, axi.araddr[1:0],
                        wr_eff.addr[1:0]};

endmodule
